// File: rtl/crossbar_alloc_pkg.sv
// Shared types and default sizing for the crossbar allocator.
package noc_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  localparam int DEF_PORTS   = 2;
  localparam int DEF_CREDITS = 4;
endpackage

// File: rtl/crossbar_alloc_if.sv
// Per-input request/grant bundle between the router inputs and the allocator.
interface crossbar_alloc_if
  import noc_pkg::*;
#(
  parameter int PORTS = DEF_PORTS
);
  localparam int IW = $clog2(PORTS);

  logic [PORTS-1:0]         req_i;
  logic [PORTS-1:0][IW-1:0] dest_i;
  logic [PORTS-1:0]         tail_i;
  logic [PORTS-1:0]         credit_i;
  logic [PORTS-1:0]         gnt_o;
  logic [PORTS-1:0][IW-1:0] dest_o;
  logic [PORTS-1:0]         dest_en_o;
  logic [PORTS-1:0]         locked_o;
  logic                     credit_err_o;

  modport master (
    output req_i, dest_i, tail_i, credit_i,
    input  gnt_o, dest_o, dest_en_o, locked_o, credit_err_o
  );

  modport slave (
    input  req_i, dest_i, tail_i, credit_i,
    output gnt_o, dest_o, dest_en_o, locked_o, credit_err_o
  );
endinterface

// File: rtl/crossbar_alloc_rr_arbiter.sv
// Round-robin arbiter: first requester strictly after ptr_i, wrapping modulo PORTS.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int PORTS = DEF_PORTS,
  localparam int IW   = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);
  int unsigned scan;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    scan  = 0;
    for (int k = 1; k <= PORTS; k++) begin
      scan = (int'(ptr_i) + k) % PORTS;
      if (!any_o && req_i[scan]) begin
        any_o       = 1'b1;
        gnt_o[scan] = 1'b1;
        idx_o       = IW'(scan);
      end
    end
  end
endmodule

// File: rtl/crossbar_alloc.sv
// Credit-aware crossbar allocator: per-output round-robin arbitration with
// packet locking (wormhole) and downstream credit tracking.
module crossbar_alloc
  import noc_pkg::*;
#(
  parameter int PORTS   = DEF_PORTS,
  parameter int CREDITS = DEF_CREDITS
) (
  input logic             clk,
  input logic             rst,
  crossbar_alloc_if.slave bus
);
  localparam int IW = $clog2(PORTS);
  localparam int CW = $clog2(CREDITS + 1);

  state_e           state_q [PORTS];
  state_e           state_d [PORTS];
  logic [IW-1:0]    owner_q [PORTS];
  logic [IW-1:0]    owner_d [PORTS];
  logic [IW-1:0]    rr_q    [PORTS];
  logic [IW-1:0]    rr_d    [PORTS];
  logic [CW-1:0]    cred_q  [PORTS];
  logic [CW-1:0]    cred_d  [PORTS];
  logic             err_q, err_d;

  logic [PORTS-1:0] cand    [PORTS];
  logic [PORTS-1:0] arb_gnt [PORTS];
  logic [IW-1:0]    arb_idx [PORTS];
  logic             arb_any [PORTS];
  logic [PORTS-1:0] gnt_all;
  logic             out_gnt;

  for (genvar o = 0; o < PORTS; o++) begin : g_out
    always_comb begin
      cand[o] = '0;
      for (int i = 0; i < PORTS; i++)
        cand[o][i] = bus.req_i[i] && (bus.dest_i[i] == IW'(o));
    end

    rr_arbiter #(.PORTS(PORTS)) u_arb (
      .req_i (cand[o]),
      .ptr_i (rr_q[o]),
      .gnt_o (arb_gnt[o]),
      .idx_o (arb_idx[o]),
      .any_o (arb_any[o])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= IW'(PORTS - 1);
        cred_q[o]  <= CW'(CREDITS);
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        cred_q[o]  <= cred_d[o];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    gnt_all = '0;
    err_d   = err_q;
    out_gnt = 1'b0;
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      cred_d[o]  = cred_q[o];
      out_gnt    = 1'b0;
      if (state_q[o] == IDLE) begin
        if (arb_any[o] && cred_q[o] != '0) begin
          out_gnt = 1'b1;
          gnt_all = gnt_all | arb_gnt[o];
          rr_d[o] = arb_idx[o];
          if (!bus.tail_i[arb_idx[o]]) begin
            state_d[o] = LOCKED;
            owner_d[o] = arb_idx[o];
          end
        end
      end else begin
        // Only the owner may advance; a wandering or idle owner just stalls the output.
        if (bus.req_i[owner_q[o]] && bus.dest_i[owner_q[o]] == IW'(o) && cred_q[o] != '0) begin
          out_gnt             = 1'b1;
          gnt_all[owner_q[o]] = 1'b1;
          if (bus.tail_i[owner_q[o]]) state_d[o] = IDLE;
        end
      end
      if (out_gnt && !bus.credit_i[o]) begin
        cred_d[o] = cred_q[o] - 1'b1;
      end else if (!out_gnt && bus.credit_i[o]) begin
        if (cred_q[o] == CW'(CREDITS)) err_d = 1'b1;
        else                           cred_d[o] = cred_q[o] + 1'b1;
      end
    end
  end

  always_comb begin
    bus.gnt_o     = rst ? gnt_all : '0;
    bus.dest_en_o = rst ? gnt_all : '0;
    bus.dest_o    = '0;
    bus.locked_o  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (rst && gnt_all[i]) bus.dest_o[i] = bus.dest_i[i];
      bus.locked_o[i] = rst && (state_q[i] == LOCKED);
    end
  end

  assign bus.credit_err_o = err_q;
endmodule

// File: doc/crossbar_alloc.md
CROSSBAR_ALLOC -- requirements
Module: crossbar_alloc

Interface
REQ-001 Parameter PORTS, default 2: number of crossbar input and output ports; must be 2 or more.
REQ-002 Parameter CREDITS, default 4: downstream buffer depth per output port, in flits; must be 1 or more.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req_i[PORTS]  input  1  input i presents a valid flit.
REQ-006 dest_i[PORTS]  input  $clog2(PORTS)  requested output port for input i; sampled only when req_i is high.
REQ-007 tail_i[PORTS]  input  1  flit on input i is the last flit of its packet.
REQ-008 credit_i[PORTS]  input  1  downstream of output o freed one flit slot this cycle.
REQ-009 gnt_o[PORTS]  output  1  flit on input i is transferred this cycle.
REQ-010 dest_o[PORTS]  output  $clog2(PORTS)  crossbar destination for input i.
REQ-011 dest_en_o[PORTS]  output  1  crossbar enable for input i; equals gnt_o[i].
REQ-012 locked_o[PORTS]  output  1  output o is owned by a packet in progress.
REQ-013 credit_err_o  output  1  sticky flag: a credit was returned while the counter was already at CREDITS.

Function
REQ-014 Each output o has a 2-state FSM: IDLE (no owner) and LOCKED (owner register holds the input index).
REQ-015 IDLE: candidates for output o are the inputs with req_i high and dest_i equal to o; the winner is the first candidate scanning from rr_ptr[o]+1 upward, modulo PORTS.
REQ-016 IDLE: a winner is granted only when cred[o] is above 0; on grant, rr_ptr[o] takes the winner index.
REQ-017 IDLE with a granted non-tail flit: go to LOCKED and latch owner[o].
REQ-018 IDLE with a granted tail flit (single-flit packet): stay in IDLE.
REQ-019 LOCKED: only owner[o] may be granted, and only when req_i[owner] is high and cred[o] is above 0; all other requesters to o get gnt_o low.
REQ-020 LOCKED with a granted tail flit: go to IDLE in the next cycle; the output becomes available for arbitration in that cycle.
REQ-021 A LOCKED owner whose req_i is low, or whose dest_i differs from o, stalls: no grant, state held.
REQ-022 Grant is combinational, with zero-cycle latency from req_i, using registered FSM state, owner, rr_ptr and cred.
REQ-023 An input is granted to at most one output per cycle, since dest_i selects a single output; gnt_o[i] is never high with req_i[i] low.
REQ-024 dest_o[i] equals dest_i[i] whenever gnt_o[i] is high, and 0 otherwise.
REQ-025 cred[o] update: decrement by 1 on a grant to o; increment by 1 on credit_i[o]; unchanged when both occur in the same cycle.
REQ-026 cred[o] range is 0 to CREDITS; the counter is $clog2(CREDITS+1) bits wide.
REQ-027 A credit_i[o] arriving with cred[o] already at CREDITS and no grant to o that cycle is ignored and sets credit_err_o.
REQ-028 locked_o[o] is high exactly when FSM[o] is in LOCKED.

Reset
REQ-029 While rst is low at a clock edge: every FSM goes to IDLE, owner goes to 0, rr_ptr goes to PORTS-1 so input 0 has first priority, cred goes to CREDITS, and credit_err_o clears.
REQ-030 While rst is low, gnt_o, dest_en_o, dest_o and locked_o are driven to 0.
REQ-031 Reset in mid-packet drops the lock with no recovery; the packet in flight is truncated.

Structure
REQ-032 Package noc_pkg holds the FSM state typedef (IDLE, LOCKED) and the default PORTS and CREDITS constants.
REQ-033 Sub-module rr_arbiter (PORTS-wide request vector plus pointer in, one-hot grant plus index out) is instantiated once per output.
REQ-034 gnt_o and dest_en_o connect directly to the crossbar's dest_en and ack sides; crossbar_alloc adds no pipeline stage.

Verification
REQ-035 Scenario 1: after reset, inputs 0 and 1 request output 0 with single-flit packets every cycle -> grants alternate 0,1,0,1; cred[0] decrements 4,3,2,1,0; grants stop at 0 credits.
REQ-036 Scenario 2: input 1 sends a 3-flit packet to output 0 while input 0 also requests output 0 -> input 1 receives 3 consecutive grants with locked_o[0] high; input 0 is granted in the cycle after the tail.
REQ-037 Scenario 3: with credits exhausted, assert credit_i[0] for one cycle -> exactly one further grant; with a grant and credit_i in the same cycle, cred stays unchanged.
REQ-038 Scenario 4: inputs 0 and 1 target outputs 1 and 0 respectively in the same cycle -> both granted; dest_o equals {1,0}.
REQ-039 Scenario 5: drop rst low during the middle flit of a locked packet -> next cycle FSM is IDLE, cred is 4, all outputs are 0.
REQ-040 Scenario 6: pulse credit_i[1] with cred[1] at 4 -> credit_err_o goes high and stays high until reset.
